// File: rtl/minpool_frame_io_if.sv
// rtl/minpool_frame_io_if.sv - serial pixel/pooled streams and parallel pooler bus of minpool_frame_io
interface minpool_frame_io_if #(
  parameter int DATA_WIDTH = 8
);
  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_WIDTH-1:0]    s_data;
  logic                     s_last;
  logic [64*DATA_WIDTH-1:0] fm_flat;
  logic                     fm_valid;
  logic [36*DATA_WIDTH-1:0] pm_flat;
  logic                     m_valid;
  logic                     m_ready;
  logic [DATA_WIDTH-1:0]    m_data;
  logic                     m_last;
  logic                     busy;
  logic                     err;

  modport master (
    output s_valid, s_data, s_last, pm_flat, m_ready,
    input  s_ready, fm_flat, fm_valid, m_valid, m_data, m_last, busy, err
  );

  modport slave (
    input  s_valid, s_data, s_last, pm_flat, m_ready,
    output s_ready, fm_flat, fm_valid, m_valid, m_data, m_last, busy, err
  );
endinterface

// File: rtl/minpool_frame_io.sv
// rtl/minpool_frame_io.sv - serial 8x8 frame in, serial 6x6 pooled result out around the parallel min-pooler
// Optional s_last framing check: MINPOOL_FRAME_IO_LAST_CHECK_EN
module minpool_frame_io #(
  parameter int DATA_WIDTH = 8,
  parameter int POOL_LAT   = 1
) (
  input logic               clk,
  input logic               rst,
  minpool_frame_io_if.slave bus
);
  typedef enum logic [1:0] {LOAD, WAIT, CAPTURE, SEND} state_t;

  localparam logic [3:0] LAT_INIT = 4'(POOL_LAT);

  state_t                state, state_nxt;
  logic [5:0]            wr_idx;
  logic [5:0]            rd_idx;
  logic [3:0]            lat_cnt;
  logic [DATA_WIDTH-1:0] fbuf [64];
  logic [DATA_WIDTH-1:0] obuf [36];
  logic                  err_q;

  logic s_ready_c, fm_valid_c, m_valid_c, m_last_c;
  logic in_fire, out_fire, bad_beat, frame_done;
  logic [64*DATA_WIDTH-1:0] fm_flat_c;

`ifdef MINPOOL_FRAME_IO_LAST_CHECK_EN
  assign bad_beat = bus.s_last != (wr_idx == 6'd63);
`else
  logic s_last_unused;
  assign s_last_unused = bus.s_last;
  assign bad_beat      = 1'b0;
`endif

  assign in_fire    = bus.s_valid && s_ready_c;
  assign out_fire   = m_valid_c && bus.m_ready;
  assign frame_done = in_fire && !bad_beat && (wr_idx == 6'd63);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (frame_done) state_nxt = WAIT;
      WAIT:    if (lat_cnt == 4'd1) state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND:    if (out_fire && rd_idx == 6'd35) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    s_ready_c  = (state == LOAD);
    fm_valid_c = (state == WAIT) || (state == CAPTURE);
    m_valid_c  = (state == SEND);
    m_last_c   = (state == SEND) && (rd_idx == 6'd35);
  end

  // A rejected beat restarts framing but leaves already-written pixels in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx  <= '0;
      rd_idx  <= '0;
      lat_cnt <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 64; i++) fbuf[i] <= '0;
      for (int e = 0; e < 36; e++) obuf[e] <= '0;
    end else begin
      if (in_fire) begin
        if (bad_beat) begin
          wr_idx <= '0;
          err_q  <= 1'b1;
        end else begin
          fbuf[wr_idx] <= bus.s_data;
          wr_idx       <= wr_idx + 6'd1;
          if (wr_idx == 6'd63) lat_cnt <= LAT_INIT;
        end
      end
      if (state == WAIT) lat_cnt <= lat_cnt - 4'd1;
      if (state == CAPTURE) begin
        for (int e = 0; e < 36; e++) obuf[e] <= bus.pm_flat[e*DATA_WIDTH +: DATA_WIDTH];
        rd_idx <= '0;
      end
      if (out_fire) rd_idx <= (rd_idx == 6'd35) ? 6'd0 : rd_idx + 6'd1;
    end
  end

  always_comb begin
    fm_flat_c = '0;
    for (int i = 0; i < 64; i++) fm_flat_c[i*DATA_WIDTH +: DATA_WIDTH] = fbuf[i];
  end

  assign bus.fm_flat  = fm_flat_c;
  assign bus.s_ready  = s_ready_c;
  assign bus.fm_valid = fm_valid_c;
  assign bus.m_valid  = m_valid_c;
  assign bus.m_last   = m_last_c;
  assign bus.m_data   = m_valid_c ? obuf[rd_idx] : '0;
  assign bus.busy     = (state != LOAD) || (wr_idx != 6'd0);
  assign bus.err      = err_q;
endmodule

// File: tb/tb_minpool_frame_io.sv
// tb/tb_minpool_frame_io.sv - randomized frame-level bench for minpool_frame_io (POOL_LAT 1 and 15)
module tb_minpool_frame_io;
  localparam int DW = 8;

  typedef struct {
    int sel;
    int pattern;
    int s_pct;
    int m_pct;
    int ovr;
    int ab_in;
    int ab_out;
    int last_at;
    int exp_fm;
  } vec_t;

  typedef struct {
    string        name;
    logic [511:0] exp;
  } rst_vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0;
  logic         s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0, ovr = 1'b0;
  logic [7:0]   s_data = '0;
  logic [287:0] ovr_val = '0;
  logic         s_ready, fm_valid, m_valid, m_last, busy, err;
  logic [7:0]   m_data;
  logic [511:0] fm_flat;
  int           checks = 0;
  int           errors = 0;
  logic         err_exp = 1'b0;
  logic [511:0] cur_fr1 = '0;
  vec_t         vecs [10];
  rst_vec_t     rst_tab [8];

  always #5 clk = ~clk;

  minpool_frame_io_if #(.DATA_WIDTH(DW)) bus1 ();
  minpool_frame_io_if #(.DATA_WIDTH(DW)) bus15 ();

  minpool_frame_io #(.DATA_WIDTH(DW), .POOL_LAT(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  minpool_frame_io #(.DATA_WIDTH(DW), .POOL_LAT(15)) dut15 (.clk(clk), .rst(rst), .bus(bus15));

  // Pooler model: 3x3 stride-1 minimum over the 8x8 map.
  function automatic logic [287:0] pool_flat(input logic [511:0] f);
    logic [287:0] o;
    logic [7:0]   m, v;
    o = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        m = 8'hff;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            v = f[((r+i)*8 + (c+j))*8 +: 8];
            if (v < m) m = v;
          end
        o[(r*6+c)*8 +: 8] = m;
      end
    return o;
  endfunction

  function automatic logic [287:0] stamp_pat(input int n);
    logic [287:0] o;
    for (int e = 0; e < 36; e++) o[e*8 +: 8] = 8'((n*37 + e*5) & 255);
    return o;
  endfunction

  assign bus1.s_valid  = s_valid && !sel;
  assign bus1.s_data   = s_data;
  assign bus1.s_last   = s_last;
  assign bus1.m_ready  = m_ready && !sel;
  assign bus1.pm_flat  = ovr ? ovr_val : pool_flat(bus1.fm_flat);
  assign bus15.s_valid = s_valid && sel;
  assign bus15.s_data  = s_data;
  assign bus15.s_last  = s_last;
  assign bus15.m_ready = m_ready && sel;
  assign bus15.pm_flat = ovr ? ovr_val : pool_flat(bus15.fm_flat);

  assign s_ready  = sel ? bus15.s_ready  : bus1.s_ready;
  assign fm_valid = sel ? bus15.fm_valid : bus1.fm_valid;
  assign m_valid  = sel ? bus15.m_valid  : bus1.m_valid;
  assign m_last   = sel ? bus15.m_last   : bus1.m_last;
  assign m_data   = sel ? bus15.m_data   : bus1.m_data;
  assign busy     = sel ? bus15.busy     : bus1.busy;
  assign err      = sel ? bus15.err      : bus1.err;
  assign fm_flat  = sel ? bus15.fm_flat  : bus1.fm_flat;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    logic [511:0] act [8];
    #1;
    act[0] = 512'(s_ready);
    act[1] = 512'(fm_valid);
    act[2] = 512'(m_valid);
    act[3] = 512'(m_last);
    act[4] = 512'(m_data);
    act[5] = 512'(busy);
    act[6] = 512'(err);
    act[7] = fm_flat;
    for (int i = 0; i < 8; i++) chk({tag, "/", rst_tab[i].name}, act[i], rst_tab[i].exp);
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    logic [511:0] fr;
    logic [287:0] pm_exp;
    logic [7:0]   prev_data;
    logic         prev_last, prev_stall, fire_in, fire_out, done, aborted;
    int           k, j, fm_cyc, cyc, lat;
    sel = (v.sel != 0);
    lat = v.sel != 0 ? 15 : 1;
    for (int i = 0; i < 64; i++)
      case (v.pattern)
        0:       fr[i*8 +: 8] = 8'(i);
        2:       fr[i*8 +: 8] = 8'(255 - 3*i);
        default: fr[i*8 +: 8] = 8'($urandom_range(0, 255));
      endcase
    pm_exp = (v.ovr != 0) ? stamp_pat(lat + 1) : pool_flat(fr);
    ovr = (v.ovr != 0);
    k = 0; j = 0; fm_cyc = 0; cyc = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    done = 1'b0; aborted = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (fm_valid) begin
        fm_cyc++;
        if (v.ovr != 0) ovr_val = stamp_pat(fm_cyc);
      end
      if (prev_stall) begin
        chk($sformatf("v%0d_hold_data", idx), 512'(m_data), 512'(prev_data));
        chk($sformatf("v%0d_hold_last", idx), 512'(m_last), 512'(prev_last));
      end
      m_ready = ($urandom_range(0, 99) < v.m_pct);
      s_valid = (k < 64) && ($urandom_range(0, 99) < v.s_pct);
      s_data  = (k < 64) ? fr[k*8 +: 8] : 8'h00;
      s_last  = (k == v.last_at);
      #1;
      fire_in  = s_valid && s_ready;
      fire_out = m_valid && m_ready;
      if (fire_out) begin
        chk($sformatf("v%0d_e%0d_data", idx, j), 512'(m_data), 512'(pm_exp[j*8 +: 8]));
        chk($sformatf("v%0d_e%0d_last", idx, j), 512'(m_last), 512'(j == 35));
        j++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      @(posedge clk);
      if (fire_in) k++;
      if (fire_out && j == 36) done = 1'b1;
      if ((v.ab_in > 0 && k == v.ab_in && fire_in) || (v.ab_out > 0 && j == v.ab_out && fire_out)) begin
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        check_reset($sformatf("v%0d_abort", idx));
        err_exp = 1'b0;
        cur_fr1 = '0;
        @(negedge clk);
        rst = 1'b0;
        aborted = 1'b1;
        done = 1'b1;
      end
    end
    ovr = 1'b0;
    if (!done) chk($sformatf("v%0d_timeout", idx), 512'(cyc), 512'(0));
    else if (!aborted) begin
      chk($sformatf("v%0d_fm_cycles", idx), 512'(fm_cyc), 512'(v.exp_fm));
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_ready_after", idx), 512'(s_ready), 512'(1));
      chk($sformatf("v%0d_mvalid_after", idx), 512'(m_valid), 512'(0));
      chk($sformatf("v%0d_busy_after", idx), 512'(busy), 512'(0));
      chk($sformatf("v%0d_err", idx), 512'(err), 512'(err_exp));
      chk($sformatf("v%0d_fm_flat", idx), fm_flat, fr);
      if (v.sel == 0) cur_fr1 = fr;
    end
  endtask

  initial begin
    rst_tab[0] = '{"s_ready", 512'(1)};
    rst_tab[1] = '{"fm_valid", 512'(0)};
    rst_tab[2] = '{"m_valid", 512'(0)};
    rst_tab[3] = '{"m_last", 512'(0)};
    rst_tab[4] = '{"m_data", 512'(0)};
    rst_tab[5] = '{"busy", 512'(0)};
    rst_tab[6] = '{"err", 512'(0)};
    rst_tab[7] = '{"fm_flat", 512'(0)};
    //          sel pat  s%   m%  ovr ab_in ab_out last fm
    vecs[0] = '{0,  0,  100, 100, 0,  0,    0,    63,  2};
    vecs[1] = '{0,  1,  50,  50,  0,  0,    0,    63,  2};
    vecs[2] = '{0,  1,  50,  50,  0,  0,    0,    63,  2};
    vecs[3] = '{1,  1,  100, 100, 1,  0,    0,    63,  16};
    vecs[4] = '{1,  1,  50,  50,  0,  0,    0,    63,  16};
    vecs[5] = '{0,  1,  100, 100, 0,  30,   0,    63,  2};
    vecs[6] = '{0,  0,  100, 100, 0,  0,    0,    63,  2};
    vecs[7] = '{0,  1,  100, 100, 0,  0,    10,   63,  2};
    vecs[8] = '{0,  2,  70,  70,  0,  0,    0,    63,  2};
    vecs[9] = '{1,  0,  100, 30,  0,  0,    0,    63,  16};

    repeat (3) @(negedge clk);
    sel = 1'b0;
    check_reset("rst_d1");
    sel = 1'b1;
    check_reset("rst_d15");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_frame(i, vecs[i]);

`ifdef MINPOOL_FRAME_IO_LAST_CHECK_EN
    begin : framing
      logic [511:0] efr;
      logic [7:0]   b;
      vec_t         good;
      sel = 1'b0;
      efr = cur_fr1;
      for (int k = 0; k < 21; k++) begin
        @(negedge clk);
        b = 8'($urandom_range(0, 255));
        s_valid = 1'b1; s_data = b; s_last = (k == 20);
        if (k < 20) efr[k*8 +: 8] = b;
      end
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0;
      #1;
      chk("frm_err", 512'(err), 512'(1));
      chk("frm_busy", 512'(busy), 512'(0));
      chk("frm_ready", 512'(s_ready), 512'(1));
      chk("frm_fm_valid", 512'(fm_valid), 512'(0));
      chk("frm_fm_flat", fm_flat, efr);
      err_exp = 1'b1;
      good = '{0, 1, 100, 100, 0, 0, 0, 63, 2};
      run_frame(10, good);
    end
`else
    begin : framing
      vec_t odd;
      odd = '{0, 1, 100, 100, 0, 0, 0, 20, 2};
      run_frame(10, odd);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/minpool_frame_io.md
# minpool_frame_io

Streaming front/back end for the 3x3, stride-1 min-pool array. The block accepts an 8x8 feature map as a serial raster pixel stream and presents it to the pooler as a packed parallel frame. After a fixed pooler latency it captures the 6x6 pooled result and streams it out serially in raster order. It is the serial-side counterpart of the pooler's parallel `feature_map`/`pooled_map` interface, so upstream DMA and downstream consumers need no 64-wide buses.

## Interface
Parameters:
- `DATA_WIDTH`, 8, pixel width in bits
- `POOL_LAT`, 1, cycles from `fm_valid` rising to `pm_flat` being stable; legal range 1..15

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `s_valid`  in  1  input pixel valid
- `s_ready`  out  1  input pixel accepted when `s_valid && s_ready`
- `s_data`  in  DATA_WIDTH  input pixel
- `s_last`  in  1  marks pixel 63 of a frame; used only with the configuration macro
- `fm_flat`  out  64*DATA_WIDTH  frame to pooler; pixel (r,c) at bits `[(r*8+c)*DATA_WIDTH +: DATA_WIDTH]`
- `fm_valid`  out  1  `fm_flat` holds a complete frame
- `pm_flat`  in  36*DATA_WIDTH  pooler result; element (r,c) at bits `[(r*6+c)*DATA_WIDTH +: DATA_WIDTH]`
- `m_valid`  out  1  output element valid
- `m_ready`  in  1  downstream accept
- `m_data`  out  DATA_WIDTH  pooled element
- `m_last`  out  1  high with element 35
- `busy`  out  1  high in any state other than LOAD, or in LOAD with `wr_idx != 0`
- `err`  out  1  sticky framing error

## Operation
- FSM states: LOAD, WAIT, CAPTURE, SEND.
- **LOAD**
  - `s_ready=1`.
  - Each accepted beat writes `s_data` to frame buffer[`wr_idx`], then increments `wr_idx` (6 bits).
  - Acceptance at `wr_idx==63` sets `wr_idx=0`, loads `lat_cnt=POOL_LAT`, and goes to WAIT.
- **WAIT**
  - `s_ready=0`, `fm_valid=1`.
  - `lat_cnt` decrements each cycle.
  - When `lat_cnt` is 1, go to CAPTURE.
- **CAPTURE** (one cycle)
  - `fm_valid=1`.
  - `pm_flat` is registered into the 36-entry output buffer.
  - Then go to SEND with `rd_idx=0`.
- **SEND**
  - `m_valid=1`, `m_data=outbuf[rd_idx]`, `m_last=(rd_idx==35)`.
  - On `m_valid && m_ready`, `rd_idx` increments.
  - The handshake on element 35 returns to LOAD.
- `fm_flat` is a direct view of the frame buffer. It changes only on accepted input beats and is never cleared between frames.
- `m_data`/`m_last` are stable while `m_valid && !m_ready`.
- No arithmetic besides the index and latency counters. Pixel values pass through unmodified.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=LOAD, `wr_idx=rd_idx=lat_cnt=0`.
  - Frame and output buffers all zero.
  - `s_ready=1`, `fm_valid=0`, `m_valid=0`, `m_last=0`, `m_data=0`, `busy=0`, `err=0`.
- Reset mid-frame or mid-SEND discards all partial data. The first beat after release is pixel 0.
- Minimum frame period: 64 (load) + `POOL_LAT` (WAIT) + 1 (CAPTURE) + 36 (send) cycles.
- `fm_valid` rises the cycle after pixel 63 is accepted and stays high for `POOL_LAT+1` cycles.
- The `pm_flat` sample occurs on the clock edge ending CAPTURE, i.e. `POOL_LAT+1` edges after `fm_valid` rises.
- The first `m_valid` appears the cycle after CAPTURE.
- `s_ready` rises the cycle after the element-35 handshake. There is no input/output overlap.
- `s_valid` low stalls LOAD indefinitely. `m_ready` low stalls SEND indefinitely. Neither affects other state.

## Configuration
- `MINPOOL_FRAME_IO_LAST_CHECK_EN` defined:
  - `s_last` is checked on every accepted beat.
  - `s_last=1` with `wr_idx!=63`, or `s_last=0` with `wr_idx==63`, sets `err=1` (sticky until reset).
  - On such a beat the pixel is discarded, `wr_idx` goes to 0, and the FSM stays in LOAD.
  - The frame buffer keeps its old contents, except pixels already overwritten by the bad frame.
- Not defined:
  - `s_last` is ignored.
  - `err` is tied 0.
  - Framing relies solely on the count of 64.

## Test plan
- **Reset values:** hold `rst=1` → `s_ready=1`, `fm_valid=0`, `m_valid=0`, `busy=0`, `err=0`, `fm_flat=0`.
- **Single frame, `POOL_LAT=1`, `m_ready=1`:**
  - Send pixels 0..63 with value `(r*8+c)`; `pm_flat` is driven by a reference 3x3 min model.
  - Expect `fm_valid` for 2 cycles, then 36 outputs where element (r,c) = `r*8+c`, and `m_last` only on the 36th.
- **Back-pressure:**
  - Random `s_valid` and `m_ready` duty (50%), two consecutive random frames.
  - Expect output to match the min model exactly, with `m_data` held stable during stalls.
- **Latency boundary:** `POOL_LAT=15`; change `pm_flat` on every cycle of WAIT → captured value equals `pm_flat` at the 16th edge after `fm_valid` rises.
- **Reset mid-operation:**
  - Assert `rst` after 30 input beats, and again after 10 SEND beats.
  - Expect a full return to reset values; the next frame processes correctly from pixel 0.
- **Framing check** (macro defined):
  - Assert `s_last` on beat 20 → `err=1` and `wr_idx` restarts; a following correct 64-beat frame is pooled normally and `err` stays 1.
  - Macro undefined: same stimulus gives `err=0`, and the frame completes on beat 63 counted from the first beat.
